// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial word feeder: FSM state encoding and default word width.
package serial_word_feeder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPrime = 2'b01,
    StShift = 2'b10,
    StDone  = 2'b11
  } state_e;

endpackage

// File: rtl/serial_word_feeder_piso_shift_reg.sv
// Parallel-in serial-out shift register; shifts toward the output end and fills with zeros.
module serial_word_feeder_piso_shift_reg #(
  parameter int unsigned Width    = 8,
  parameter bit          LsbFirst = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             shift_i,
  output logic             ser_o
);

  logic [Width-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = LsbFirst ? {1'b0, shreg_q[Width-1:1]} : {shreg_q[Width-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign ser_o = LsbFirst ? shreg_q[0] : shreg_q[Width-1];

endmodule

// File: rtl/serial_word_feeder.sv
// Accepts a parallel word, pulses the downstream FSM reset, then streams the word one bit per
// clock and flags the end of the word. All outputs are decoded from registered state only.
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             fsm_rst,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load, shift, piso_bit;

  serial_word_feeder_piso_shift_reg #(
    .Width    (WIDTH),
    .LsbFirst (LSB_FIRST)
  ) u_piso (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .data_i  (load_data),
    .shift_i (shift),
    .ser_o   (piso_bit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    shift      = 1'b0;
    load_ready = 1'b0;
    ser_bit    = 1'b0;
    ser_valid  = 1'b0;
    fsm_rst    = 1'b0;
    busy       = 1'b0;
    word_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        load_ready = 1'b1;
        if (load_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = StPrime;
        end
      end
      StPrime: begin
        fsm_rst = 1'b1;
        busy    = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        ser_valid = 1'b1;
        ser_bit   = piso_bit;
        busy      = 1'b1;
        shift     = 1'b1;
        // Hold the counter on the last bit so it never wraps inside a word.
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        word_done = 1'b1;
        busy      = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: an offset-from-accept model checked every cycle on an LSB-first
// and an MSB-first instance, plus hand-computed bit streams and timing.
module tb_serial_word_feeder;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, load_valid;
  logic [W-1:0] load_data;
  logic lr_l, sb_l, sv_l, fr_l, bz_l, wd_l;
  logic lr_m, sb_m, sv_m, fr_m, bz_m, wd_m;

  serial_word_feeder #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr_l), .ser_bit(sb_l), .ser_valid(sv_l), .fsm_rst(fr_l), .busy(bz_l),
    .word_done(wd_l)
  );

  serial_word_feeder #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr_m), .ser_bit(sb_m), .ser_valid(sv_m), .fsm_rst(fr_m), .busy(bz_m),
    .word_done(wd_m)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: m_off is the cycle number relative to the accept edge, -1 when idle.
  int           m_off  = -1;
  logic [W-1:0] m_word = '0;
  always @(posedge clk) begin
    if (rst) m_off <= -1;
    else if (m_off < 0) begin
      if (load_valid) begin
        m_off  <= 1;
        m_word <= load_data;
      end
    end else if (m_off == W + 2) m_off <= -1;
    else m_off <= m_off + 1;
  end

  // {load_ready, ser_bit, ser_valid, fsm_rst, busy, word_done}
  function automatic logic [5:0] expect_vec(bit lsb);
    logic [5:0] v;
    int         i;
    v = '0;
    if (m_off < 0) v[5] = 1'b1;
    else if (m_off == 1) begin
      v[2] = 1'b1;
      v[1] = 1'b1;
    end else if (m_off <= W + 1) begin
      i    = m_off - 2;
      v[4] = lsb ? m_word[i] : m_word[W-1-i];
      v[3] = 1'b1;
      v[1] = 1'b1;
    end else begin
      v[1] = 1'b1;
      v[0] = 1'b1;
    end
    return v;
  endfunction

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("lsb_outputs", {26'd0, lr_l, sb_l, sv_l, fr_l, bz_l, wd_l}, {26'd0, expect_vec(1'b1)});
      check("msb_outputs", {26'd0, lr_m, sb_m, sv_m, fr_m, bz_m, wd_m}, {26'd0, expect_vec(1'b0)});
    end
  end

  // Stream capture: first bit sent ends up in the MSB of stream_*.
  logic [W-1:0] sh_l = '0, sh_m = '0, stream_l = '0, stream_m = '0;
  int prime_cyc = -1, prev_prime = -1, done_cyc = -1, done_cnt = 0;
  always @(negedge clk) begin
    if (fr_l) begin
      prev_prime <= prime_cyc;
      prime_cyc  <= cyc;
      sh_l       <= '0;
      sh_m       <= '0;
    end
    if (sv_l) sh_l <= {sh_l[W-2:0], sb_l};
    if (sv_m) sh_m <= {sh_m[W-2:0], sb_m};
    if (wd_l) begin
      stream_l <= sh_l;
      stream_m <= sh_m;
      done_cyc <= cyc;
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic accept(input logic [W-1:0] d, output int acc);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    int acc, acc1, dc;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    check("reset_outputs", {26'd0, lr_l, sb_l, sv_l, fr_l, bz_l, wd_l}, 32'b100000);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 check("idle_outputs", {26'd0, lr_m, sb_m, sv_m, fr_m, bz_m, wd_m}, 32'b100000);
    end

    // 8'hB4 on both bit orders
    accept(8'hB4, acc);
    repeat (10) @(posedge clk);
    #1;
    check("b4_lsb_stream", stream_l, 8'b00101101);
    check("b4_msb_stream", stream_m, 8'b10110100);
    check("b4_prime_cycle", prime_cyc, acc);
    check("b4_done_cycle", done_cyc, acc + W + 1);
    check("b4_ready_again", lr_l, 1);

    // load_valid held high across two words
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'h01;
    @(posedge clk);
    #1 acc1 = cyc;
    @(negedge clk);
    load_data = 8'h80;
    repeat (10) @(posedge clk);
    #1;
    check("held_w1_lsb", stream_l, 8'b10000000);
    check("held_w1_msb", stream_m, 8'b00000001);
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("held_w2_lsb", stream_l, 8'b00000001);
    check("held_w2_msb", stream_m, 8'b10000000);
    check("held_spacing", prime_cyc - prev_prime, 11);
    check("held_w2_prime", prime_cyc, acc1 + 11);

    // load traffic while busy is ignored
    accept(8'h00, acc);
    @(negedge clk);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    repeat (7) @(negedge clk);
    load_valid = 1'b0;
    @(posedge clk);
    #1;
    check("busy_ignore_lsb", stream_l, 8'h00);
    check("busy_ignore_msb", stream_m, 8'h00);
    check("busy_ignore_prime", prime_cyc, acc);

    // reset in the middle of a word
    dc = done_cnt;
    accept(8'hFF, acc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_state", {29'd0, lr_l, sv_l, bz_l}, 32'b100);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1 check("midrst_no_done", done_cnt, dc);
    accept(8'h0F, acc);
    repeat (10) @(posedge clk);
    #1;
    check("after_rst_lsb", stream_l, 8'b11110000);
    check("after_rst_msb", stream_m, 8'b00001111);

    // rst and load_valid at the same edge
    @(negedge clk);
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hAA;
    @(posedge clk);
    #1 check("rst_beats_load", {30'd0, lr_m, bz_m}, 32'b10);
    @(negedge clk);
    rst        = 1'b0;
    load_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream stage for the bit-serial FSM block. Accepts a parallel word over a valid/ready handshake and serialises it one bit per clock onto the FSM's serial input.
- Issues a one-cycle FSM reset pulse before each word, so every word is processed from the FSM's initial state.
- Flags the end of the word.

Parameters:
- WIDTH, 8: data word width; legal range is WIDTH >= 2.
- LSB_FIRST, 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  a word is offered on load_data.
- load_data  in  WIDTH  parallel word to serialise.
- load_ready  out  1  block can accept a word (IDLE only).
- ser_bit  out  1  serial data bit; drives the FSM's inp.
- ser_valid  out  1  ser_bit carries a word bit this cycle.
- fsm_rst  out  1  one-cycle reset pulse for the downstream FSM, ORed there with the system rst.
- busy  out  1  a word is in flight (PRIME, SHIFT or DONE).
- word_done  out  1  one-cycle pulse after the last bit has been sent.

Behaviour:
- Reset: rst is synchronous and active-high, and takes effect at the clock edge.
  - After the reset edge: state=IDLE, shift register=0, bit counter=0.
  - Outputs after the reset edge: ser_bit=0, ser_valid=0, fsm_rst=0, busy=0, word_done=0, load_ready=1.
  - rst has priority over every other input.
- Moore machine: all outputs are decoded from registered state, counter and shift register only. There is no combinational path from any input to any output.
- States:
  - IDLE: load_ready=1. When load_valid=1 at an edge, capture load_data into the shift register, clear the counter, and go to PRIME.
  - PRIME: lasts exactly 1 cycle. fsm_rst=1, ser_valid=0, busy=1. Then go to SHIFT.
  - SHIFT: lasts exactly WIDTH cycles. ser_valid=1, busy=1.
    - ser_bit = shreg[0] if LSB_FIRST=1, else shreg[WIDTH-1].
    - Each edge: shift toward the output end, fill with 0, and increment the counter.
    - When the counter reaches WIDTH-1, go to DONE.
  - DONE: lasts 1 cycle. word_done=1, busy=1, ser_valid=0. Then go to IDLE.
- Timing, with the accept edge at cycle 0:
  - fsm_rst high in cycle 1.
  - Bits in cycles 2..WIDTH+1.
  - word_done in cycle WIDTH+2.
  - load_ready high again in cycle WIDTH+3.
  - Minimum spacing between accepts is WIDTH+3 cycles.
- Counter width: $clog2(WIDTH) bits. It never wraps inside a word and is cleared on accept.
- ser_bit is 0 whenever ser_valid=0.
- Boundary conditions:
  - load_valid or load_data toggling while busy: ignored; the in-flight word is unaffected.
  - load_valid held high continuously: a new word is accepted on the first IDLE edge. Exactly one IDLE cycle separates words.
  - rst asserted mid-word (any state): the partial word is discarded, no word_done is issued, and the block returns to the reset values above on the next edge.
  - rst and load_valid at the same edge: rst wins; the word is not accepted.

Decomposition:
- Shared package/header holds:
  - State encoding constants: IDLE=2'b00, PRIME=2'b01, SHIFT=2'b10, DONE=2'b11.
  - Default WIDTH.
- Sub-module piso_shift_reg (parallel load, shift enable, LSB_FIRST direction, serial out). It is instantiated once, with the FSM and counter kept in the top-level block.

Test Plan:
- Reset for 2 cycles, then release -> ser_valid=0, fsm_rst=0, busy=0, word_done=0, load_ready=1; outputs stable for 5 idle cycles.
- WIDTH=8, LSB_FIRST=1, load 8'hB4:
  - fsm_rst=1 in cycle 1.
  - ser_bit=0,0,1,0,1,1,0,1 with ser_valid=1 in cycles 2..9.
  - word_done=1 in cycle 10; load_ready=1 in cycle 11.
- WIDTH=8, LSB_FIRST=0, load 8'hB4 -> ser_bit=1,0,1,1,0,1,0,0 in cycles 2..9; same timing as above.
- load_valid held high, 8'h01 then 8'h80 -> accepts are 11 cycles apart; streams are 1,0,0,0,0,0,0,0 and 0,0,0,0,0,0,0,1; each stream is preceded by its own fsm_rst pulse.
- load_valid=1 with load_data=8'hFF during SHIFT of 8'h00 -> no accept; the stream stays all zeros; load_ready stays 0 until cycle 11.
- rst at the 4th bit of 8'hFF -> next cycle IDLE, ser_valid=0, no word_done; a subsequent load of 8'h0F streams 1,1,1,1,0,0,0,0 correctly.
